// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-side blocks: load/fetch FSM encoding,
// fault flag bit positions and the default filler word.
package mips_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2
   } imem_state_e;

   localparam int unsigned FAULT_MISALIGN = 0;
   localparam int unsigned FAULT_RANGE    = 1;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Single-port RAM with synchronous write and synchronous read; read data holds while re_i is low.
module imem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: word-serial program load after reset, then a registered
// fetch port with stall hold and misalign/out-of-range fault flags.
module imem_loadable
   import mips_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            MEM_DEPTH  = 64,
   parameter logic [31:0]            RESET_PC   = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0]  NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load_start,
   input  logic                  i_load_valid,
   input  logic                  i_load_last,
   input  logic [DATA_WIDTH-1:0] i_load_data,
   output logic                  o_load_ready,
   output logic                  o_load_done,
   input  logic                  i_fetch_req,
   input  logic                  i_stall,
   input  logic [31:0]           i_PC,
   output logic [DATA_WIDTH-1:0] o_instruction,
   output logic [31:0]           o_PC,
   output logic                  o_valid,
   output logic [1:0]            o_fault,
   output logic                  o_running
);

   localparam int unsigned   AW       = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

   imem_state_e     state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            done_q, done_d;
   logic            valid_q, valid_d;
   logic [1:0]      fault_q, fault_d;
   logic [31:0]     pc_q, pc_d;

   logic [31:0]           word_idx;
   logic                  misalign;
   logic                  out_of_range;
   logic                  accept;
   logic                  final_word;
   logic                  fetch_fire;
   logic                  mem_re;
   logic [AW-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0] rdata;

   // Range check at full width so large PCs never alias onto low words.
   assign word_idx     = {2'b00, i_PC[31:2]};
   assign misalign     = |i_PC[1:0];
   assign out_of_range = word_idx >= MEM_DEPTH;

   // A restart in the same cycle as a load word discards that word.
   assign accept     = (state_q == StLoad) && i_load_valid && !i_load_start;
   assign final_word = i_load_last || (ptr_q == LAST_IDX);
   assign fetch_fire = (state_q == StRun) && !i_load_start && i_fetch_req && !i_stall;
   assign mem_re     = fetch_fire && !misalign && !out_of_range;
   assign mem_addr   = (state_q == StLoad) ? ptr_q : word_idx[AW-1:0];

   imem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .ADDR_WIDTH (AW)
   ) u_array (
      .clk_i   (i_clk),
      .we_i    (accept),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .wdata_i (i_load_data),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      fault_d = fault_q;
      pc_d    = pc_q;
      unique case (state_q)
         StIdle: begin
            if (i_load_start) begin
               state_d = StLoad;
               ptr_d   = '0;
            end
         end
         StLoad: begin
            if (i_load_start) begin
               ptr_d = '0;
            end else if (accept) begin
               ptr_d = ptr_q + AW'(1);
               if (final_word) begin
                  state_d = StRun;
                  done_d  = 1'b1;
               end
            end
         end
         StRun: begin
            if (i_load_start) begin
               state_d = StLoad;
               ptr_d   = '0;
               valid_d = 1'b0;
               fault_d = 2'b00;
            end else if (!i_stall) begin
               valid_d = i_fetch_req;
               fault_d = 2'b00;
               if (i_fetch_req) begin
                  pc_d                    = i_PC;
                  fault_d[FAULT_MISALIGN] = misalign;
                  fault_d[FAULT_RANGE]    = out_of_range;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 2'b00;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
         pc_q    <= pc_d;
      end
   end

   // RAM read data is only refreshed on a clean fetch, so faults and idle slots show NOP_WORD.
   assign o_instruction = (valid_q && (fault_q == 2'b00)) ? rdata : NOP_WORD;
   assign o_PC          = pc_q;
   assign o_valid       = valid_q;
   assign o_fault       = fault_q;
   assign o_load_ready  = (state_q == StLoad);
   assign o_load_done   = done_q;
   assign o_running     = (state_q == StRun);

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a 64-deep and a 4-deep instance share one stimulus stream and are
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_imem_loadable;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start, load_valid, load_last;
   logic [31:0] load_data;
   logic        fetch_req, stall;
   logic [31:0] fetch_pc;

   logic [1:0]  ready, done, valid, running;
   logic [31:0] ins [2];
   logic [31:0] pc [2];
   logic [1:0]  fault [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_loadable u_dut64 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_load_start  (load_start),
      .i_load_valid  (load_valid),
      .i_load_last   (load_last),
      .i_load_data   (load_data),
      .o_load_ready  (ready[0]),
      .o_load_done   (done[0]),
      .i_fetch_req   (fetch_req),
      .i_stall       (stall),
      .i_PC          (fetch_pc),
      .o_instruction (ins[0]),
      .o_PC          (pc[0]),
      .o_valid       (valid[0]),
      .o_fault       (fault[0]),
      .o_running     (running[0])
   );

   imem_loadable #(
      .MEM_DEPTH (4),
      .RESET_PC  (32'h0000_0040)
   ) u_dut4 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_load_start  (load_start),
      .i_load_valid  (load_valid),
      .i_load_last   (load_last),
      .i_load_data   (load_data),
      .o_load_ready  (ready[1]),
      .o_load_done   (done[1]),
      .i_fetch_req   (fetch_req),
      .i_stall       (stall),
      .i_PC          (fetch_pc),
      .o_instruction (ins[1]),
      .o_PC          (pc[1]),
      .o_valid       (valid[1]),
      .o_fault       (fault[1]),
      .o_running     (running[1])
   );

   function automatic int unsigned depth_of(input int k);
      return (k == 0) ? 64 : 4;
   endfunction

   function automatic logic [31:0] reset_pc_of(input int k);
      return (k == 0) ? 32'h0 : 32'h40;
   endfunction

   function automatic logic [1:0] fault_of(input logic [31:0] a, input int k);
      logic [1:0] f;
      f[0] = (a % 4) != 0;
      f[1] = (a / 4) >= depth_of(k);
      return f;
   endfunction

   // Model: mode 0 idle, 1 loading, 2 running.
   int          m_mode  [2];
   int          m_ptr   [2];
   logic        m_done  [2];
   logic        m_valid [2];
   logic [1:0]  m_fault [2];
   logic [31:0] m_pc    [2];
   logic [31:0] m_ins   [2];
   logic [31:0] m_mem   [2][64];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_mode[k]  <= 0;
            m_ptr[k]   <= 0;
            m_done[k]  <= 1'b0;
            m_valid[k] <= 1'b0;
            m_fault[k] <= 2'b00;
            m_pc[k]    <= reset_pc_of(k);
            m_ins[k]   <= NOP;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_done[k] <= 1'b0;
            if (m_mode[k] == 0) begin
               if (load_start) begin
                  m_mode[k] <= 1;
                  m_ptr[k]  <= 0;
               end
            end else if (m_mode[k] == 1) begin
               if (load_start) begin
                  m_ptr[k] <= 0;
               end else if (load_valid) begin
                  m_mem[k][m_ptr[k]] <= load_data;
                  m_ptr[k] <= m_ptr[k] + 1;
                  if (load_last || (m_ptr[k] + 1 == int'(depth_of(k)))) begin
                     m_mode[k] <= 2;
                     m_done[k] <= 1'b1;
                  end
               end
            end else begin
               if (load_start) begin
                  m_mode[k]  <= 1;
                  m_ptr[k]   <= 0;
                  m_valid[k] <= 1'b0;
                  m_fault[k] <= 2'b00;
                  m_ins[k]   <= NOP;
               end else if (!stall) begin
                  if (fetch_req) begin
                     m_valid[k] <= 1'b1;
                     m_pc[k]    <= fetch_pc;
                     m_fault[k] <= fault_of(fetch_pc, k);
                     m_ins[k]   <= (fault_of(fetch_pc, k) != 2'b00) ? NOP
                                   : m_mem[k][fetch_pc[7:2]];
                  end else begin
                     m_valid[k] <= 1'b0;
                     m_ins[k]   <= NOP;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h want %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            chk("model ready", k, 32'(ready[k]), 32'(m_mode[k] == 1));
            chk("model running", k, 32'(running[k]), 32'(m_mode[k] == 2));
            chk("model done", k, 32'(done[k]), 32'(m_done[k]));
            chk("model valid", k, 32'(valid[k]), 32'(m_valid[k]));
            chk("model pc", k, pc[k], m_pc[k]);
            if (m_valid[k]) begin
               chk("model fault", k, 32'(fault[k]), 32'(m_fault[k]));
               chk("model ins", k, ins[k], m_ins[k]);
            end else begin
               chk("model idle ins", k, ins[k], NOP);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_state();
      for (int k = 0; k < 2; k++) begin
         chk("rst ready", k, 32'(ready[k]), 32'd0);
         chk("rst done", k, 32'(done[k]), 32'd0);
         chk("rst valid", k, 32'(valid[k]), 32'd0);
         chk("rst fault", k, 32'(fault[k]), 32'd0);
         chk("rst running", k, 32'(running[k]), 32'd0);
         chk("rst ins", k, ins[k], NOP);
      end
      chk("rst pc", 0, pc[0], 32'h0);
      chk("rst pc", 1, pc[1], 32'h40);
   endtask

   logic [31:0] prog [4];

   initial begin
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0003;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'h0000_0000;
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
      fetch_req = 1'b0; stall = 1'b0; fetch_pc = '0;
      repeat (2) cyc();
      chk_reset_state();
      rst_n = 1'b1;
      cyc();

      // Four-word program, last flagged on the fourth word.
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 3);
         cyc();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("t1 done", k, 32'(done[k]), 32'd1);
         chk("t1 running", k, 32'(running[k]), 32'd1);
      end

      fetch_req = 1'b1;
      fetch_pc  = 32'h8;
      cyc();
      chk("t2 ins", 0, ins[0], 32'h0109_5020);
      chk("t2 pc", 0, pc[0], 32'h8);
      chk("t2 valid", 0, 32'(valid[0]), 32'd1);
      chk("t2 fault", 0, 32'(fault[0]), 32'd0);
      chk("t2 done gone", 0, 32'(done[0]), 32'd0);

      fetch_pc = 32'h6;
      cyc();
      chk("t3 misalign", 0, 32'(fault[0]), 32'd1);
      chk("t3 misalign ins", 0, ins[0], NOP);
      fetch_pc = 32'h100;
      cyc();
      chk("t3 range", 0, 32'(fault[0]), 32'd2);
      chk("t3 range", 1, 32'(fault[1]), 32'd2);
      fetch_pc = 32'h10;
      cyc();
      chk("t3 edge range", 1, 32'(fault[1]), 32'd2);
      chk("t3 edge in range", 0, 32'(fault[0]), 32'd0);

      fetch_pc = 32'h4;
      cyc();
      chk("t4 ins", 0, ins[0], 32'h2009_0003);
      stall    = 1'b1;
      fetch_pc = 32'hC;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t4 stall ins", 0, ins[0], 32'h2009_0003);
         chk("t4 stall pc", 0, pc[0], 32'h4);
         chk("t4 stall valid", 0, 32'(valid[0]), 32'd1);
      end
      stall = 1'b0;
      cyc();
      chk("t4 resume pc", 0, pc[0], 32'hC);
      fetch_req = 1'b0;
      cyc();
      chk("t4 idle valid", 0, 32'(valid[0]), 32'd0);

      // Five words, no last: the 4-deep instance must stop after four.
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = 32'h1111_1111 * 32'(i + 1);
         cyc();
         if (i == 3) begin
            chk("t5 running", 1, 32'(running[1]), 32'd1);
            chk("t5 done", 1, 32'(done[1]), 32'd1);
            chk("t5 still loading", 0, 32'(running[0]), 32'd0);
         end
      end
      load_valid = 1'b0;
      chk("t5 not ready", 1, 32'(ready[1]), 32'd0);
      chk("t5 ready", 0, 32'(ready[0]), 32'd1);
      fetch_req = 1'b1;
      fetch_pc  = 32'h0;
      cyc();
      chk("t5 word0 kept", 1, ins[1], 32'h1111_1111);
      chk("t5 no fetch in load", 0, 32'(valid[0]), 32'd0);
      fetch_pc = 32'hC;
      cyc();
      chk("t5 word3", 1, ins[1], 32'h4444_4444);

      // Load request beats a simultaneous fetch.
      load_start = 1'b1;
      fetch_pc   = 32'h0;
      cyc();
      chk("t6 load wins valid", 1, 32'(valid[1]), 32'd0);
      chk("t6 load wins ready", 1, 32'(ready[1]), 32'd1);
      load_start = 1'b0;
      fetch_req  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hBBBB_0000 + 32'(i);
         cyc();
      end
      load_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      cyc();
      cyc();
      rst_n     = 1'b1;
      fetch_req = 1'b1;
      fetch_pc  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t6 no fetch", 0, 32'(valid[0]), 32'd0);
         chk("t6 no fetch", 1, 32'(valid[1]), 32'd0);
      end

      fetch_pc   = 32'h4;
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hAAAA_0001 + 32'(i);
         load_last  = (i == 1);
         cyc();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      cyc();
      chk("t6 reload ins", 0, ins[0], 32'hAAAA_0002);
      chk("t6 reload ins", 1, ins[1], 32'hAAAA_0002);
      fetch_req = 1'b0;
      cyc();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
